// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Multi-read, dual-write register file with a per-register busy
//            (scoreboard) bit. Register 0 is hardwired to zero and never busy.
//            Optional same-cycle write-to-read bypass is compiled in only when
//            the macro REGFILE_SB_BYPASS_EN is defined.
// Ports    : clk_i        - clock, all state updates on the rising edge
//            rst_i        - synchronous active-high reset
//            rs_addr_i    - NRD packed read addresses (port k: [k*AW +: AW])
//            rs_data_o    - NRD packed read data, combinational
//            rs_busy_o    - per read port, addressed register has a pending write
//            wr0_*        - write port 0 (ALU writeback)
//            wr1_*        - write port 1 (memory writeback), wins over wr0
//            issue_en_i / issue_rd_i - mark destination register busy
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic                wr0_en_i,
  input  logic [AW-1:0]       wr0_addr_i,
  input  logic [XLEN-1:0]     wr0_data_i,
  input  logic                wr1_en_i,
  input  logic [AW-1:0]       wr1_addr_i,
  input  logic [XLEN-1:0]     wr1_data_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_rd_i
);

  localparam int NREG = 1 << AW;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next-state data: wr1 is applied after wr0 so it wins on an address clash.
  // Entry 0 is forced to zero so it can be read without special casing.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr0_en_i && (wr0_addr_i == AW'(i))) regs_d[i] = wr0_data_i;
      if (wr1_en_i && (wr1_addr_i == AW'(i))) regs_d[i] = wr1_data_i;
    end
    regs_d[0] = '0;
  end

  // Busy next-state: writes clear, issue sets afterwards so set wins.
  // Issuing to an already-busy register simply leaves it set (no counting).
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr0_en_i && (wr0_addr_i == AW'(i))) busy_d[i] = 1'b0;
      if (wr1_en_i && (wr1_addr_i == AW'(i))) busy_d[i] = 1'b0;
      if (issue_en_i && (issue_rd_i == AW'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  // Independent read ports; any number may address the same register.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rd_busy;

    assign rd_addr = rs_addr_i[k*AW +: AW];

    always_comb begin
      rd_data = regs_q[rd_addr];
      rd_busy = busy_q[rd_addr] & (rd_addr != '0);
`ifdef REGFILE_SB_BYPASS_EN
      // Forward a write landing this cycle; the register is then no longer
      // pending unless the same cycle re-issues it. Disabled under reset so
      // the outputs show the stored state.
      if (!rst_i && (rd_addr != '0)) begin
        if (wr1_en_i && (wr1_addr_i == rd_addr)) begin
          rd_data = wr1_data_i;
          rd_busy = issue_en_i && (issue_rd_i == rd_addr);
        end else if (wr0_en_i && (wr0_addr_i == rd_addr)) begin
          rd_data = wr0_data_i;
          rd_busy = issue_en_i && (issue_rd_i == rd_addr);
        end
      end
`endif
    end

    assign rs_data_o[k*XLEN +: XLEN] = rd_data;
    assign rs_busy_o[k]              = rd_busy;
  end : g_rd

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter AW, default 5, register address width; register count NREG = 2**AW.
REQ-003 SHALL provide parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port rs_addr_i  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-007 SHALL have port rs_data_o  out  NRD*XLEN  packed read data, combinational.
REQ-008 SHALL have port rs_busy_o  out  NRD  per read port: addressed register has a pending write.
REQ-009 SHALL have ports wr0_en_i / wr0_addr_i / wr0_data_i  in  1/AW/XLEN  write port 0 (ALU writeback).
REQ-010 SHALL have ports wr1_en_i / wr1_addr_i / wr1_data_i  in  1/AW/XLEN  write port 1 (memory writeback).
REQ-011 SHALL have ports issue_en_i / issue_rd_i  in  1/AW  marks destination register busy on issue.

Function
REQ-012 SHALL hold NREG registers of XLEN bits; register 0 SHALL always read 0, ignore writes, and never be busy.
REQ-013 SHALL write wrN_data_i to wrN_addr_i at the clock edge when wrN_en_i=1 and wrN_addr_i!=0.
REQ-014 SHALL, when both write ports target the same nonzero address in one cycle, store wr1_data_i (port 1 wins).
REQ-015 SHALL keep a busy bit per register: issue_en_i=1 with issue_rd_i!=0 sets busy[issue_rd_i] at the edge.
REQ-016 SHALL clear busy[a] at the edge when either write port writes nonzero address a.
REQ-017 SHALL, when issue and write target the same register in one cycle, leave the busy bit set (set wins over clear).
REQ-018 SHALL drive rs_busy_o[k] = busy[rs_addr k], gated to 0 for address 0.
REQ-019 SHALL drive rs_data_o[k] = register[rs_addr k] with zero read latency, subject to REQ-023.
REQ-020 SHALL treat issue_en_i on an already-busy register as a no-op for the busy bit (no counting).
REQ-021 SHALL leave all read ports independent; any number may address the same register.

Reset
REQ-022 SHALL, while rst_i=1 at an edge, clear all registers to 0 and all busy bits to 0, ignoring write and issue inputs that cycle; outputs reflect cleared state from the following cycle.

Configuration
REQ-023 SHALL compile same-cycle bypass only when macro REGFILE_SB_BYPASS_EN is defined: a read of nonzero address a matching an enabled write returns that write data (wr1 over wr0) and rs_busy_o reads 0 unless issue_rd_i=a with issue_en_i=1.
REQ-024 SHALL, without REGFILE_SB_BYPASS_EN, return pre-edge stored data and the registered busy bit; written data is visible the cycle after the write.
REQ-025 SHALL suppress bypass while rst_i=1; outputs then show stored state.

Verification
REQ-026 Reset, then read x1..x31 on all ports -> all data 0, all busy 0.
REQ-027 wr0 x5=0x1234_5678 and wr1 x5=0xDEAD_BEEF same cycle -> next cycle x5 reads 0xDEAD_BEEF.
REQ-028 issue x7 at cycle 1, wr1 x7=0x42 at cycle 4 -> rs_busy 1 in cycles 2-4, 0 from cycle 5, data 0x42 from cycle 5.
REQ-029 issue x9 and wr0 x9=0x11 in same cycle -> next cycle busy(x9)=1, data 0x11.
REQ-030 Write x0=0xFFFF_FFFF and issue x0 -> x0 reads 0, busy 0; with BYPASS_EN, wr0 x3=0xAA read x3 same cycle -> 0xAA, busy 0; without -> old value.
REQ-031 Assert rst_i mid-sequence with x7 busy and pending wr1 x7 -> next cycle x7 data 0, busy 0.
